tt_sweeper: RTL
===============

# tt_sweeper

Sequential truth-table sweeper for the small combinational exercise designs. It is the driving and checking end of the `sel`/`result` interface. On `start_i` it walks every selector code from 0 to 2**WIDTH-1 on `sel_o` and samples the single-bit `result_i` after a programmable settle time. When the sweep ends it reports the captured truth table, a pass/fail flag against a parameterised golden table, a mismatch count and the first failing index. It sits in the exercise top, between board/bench control and the design under test.

## Interface

Parameters:
- `WIDTH`, default 3: selector width; the sweep covers 2**WIDTH codes.
- `SETTLE`, default 0: extra cycles each code is held before sampling; must be ≥ 0.
- `EXPECTED`, default 8'hA5: golden table, width 2**WIDTH; bit i is the required result for `sel` = i. Default is 1 at codes 0, 2, 5, 7.

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `start_i`  in  1  start request; sampled only in IDLE
- `sel_o`  out  WIDTH  selector driven to the DUT
- `result_i`  in  1  DUT output, combinational from `sel_o`
- `busy_o`  out  1  high while sweeping
- `done_o`  out  1  one-cycle pulse when the sweep finishes
- `table_o`  out  2**WIDTH  captured truth table; bit i is the result sampled for code i
- `pass_o`  out  1  1 when `table_o` == `EXPECTED`
- `mismatch_count_o`  out  WIDTH+1  number of codes where the sampled result differs from `EXPECTED`
- `fail_idx_o`  out  WIDTH  lowest mismatching code; 0 if none

## Operation

- **FSM states:** IDLE, DRIVE, DONE.
- **IDLE:**
  - `sel_o` = 0, `busy_o` = 0.
  - Result outputs hold the values from the last sweep.
  - `start_i` = 1 → DRIVE. On entry: `sel_o` ← 0, settle counter ← `SETTLE`, and `table_o`, `pass_o`, `mismatch_count_o`, `fail_idx_o` ← 0.
- **DRIVE:**
  - `busy_o` = 1.
  - While the settle counter ≠ 0, decrement it and hold `sel_o`.
  - When the settle counter = 0, sample `result_i` at the clock edge:
    - Write the sample into `table_o[sel_o]`.
    - If the sample ≠ `EXPECTED[sel_o]`: increment `mismatch_count_o`. If this is the first mismatch, load `fail_idx_o` ← `sel_o`.
  - After that sample:
    - If `sel_o` = 2**WIDTH-1 → DONE.
    - Otherwise `sel_o` ← `sel_o`+1 and reload the settle counter.
  - `sel_o` never wraps inside a sweep.
- **DONE:**
  - Lasts exactly one cycle: `done_o` = 1, `busy_o` = 0, `sel_o` = 0.
  - `pass_o` = (`mismatch_count_o` == 0), registered on entry to DONE.
  - Then → IDLE.
- **`start_i` outside IDLE** (DRIVE or DONE): ignored; no queuing.
- **Reset:**
  - `rst_i` = 1 at any clock edge forces IDLE. This includes mid-sweep, and reset has priority over `start_i`.
  - Reset values: `sel_o` = 0, `busy_o` = 0, `done_o` = 0, `table_o` = 0, `pass_o` = 0, `mismatch_count_o` = 0, `fail_idx_o` = 0, settle counter = 0.
  - A partial sweep is discarded.
- **Counter widths:**
  - `mismatch_count_o` is WIDTH+1 bits, so it holds the value 2**WIDTH without overflow.
  - The settle counter is max(1, clog2(`SETTLE`+1)) bits.

## Timing

- `start_i` sampled high at edge k, in IDLE → `busy_o` = 1 and `sel_o` = 0 from cycle k+1.
- Each code i is driven for `SETTLE`+1 cycles. `result_i` is sampled at the final edge of that window.
- `done_o` is high in cycle k+1+2**WIDTH·(`SETTLE`+1). For the defaults this is k+9.
- All result outputs are registered. They are final and stable in the `done_o` cycle and hold until the next accepted start or reset.
- `busy_o` and `done_o` are never high together.

## Test plan

- **Golden DUT, defaults.** Bench model returns 1 for codes 0, 2, 5, 7; pulse `start_i` at k. Required:
  - `sel_o` steps 0..7 in cycles k+1..k+8.
  - `done_o` in cycle k+9.
  - `table_o` = 8'hA5, `pass_o` = 1, `mismatch_count_o` = 0, `fail_idx_o` = 0.
- **Single fault.** Model also returns 1 at code 3. Required: `table_o` = 8'hAD, `pass_o` = 0, `mismatch_count_o` = 1, `fail_idx_o` = 3.
- **Stuck-at-0 DUT.** `result_i` = 0 constantly. Required: `table_o` = 8'h00, `mismatch_count_o` = 4, `fail_idx_o` = 0, `pass_o` = 0.
- **Settle time, `SETTLE` = 2.** Golden model. Required:
  - Each code held 3 cycles.
  - Glitch values injected in the first 2 cycles of each code are not captured.
  - `done_o` at k+25; `table_o` = 8'hA5.
- **Reset mid-sweep.** Assert `rst_i` for one cycle while `sel_o` = 4. Required:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - No `done_o` pulse follows.
  - A new start then yields a complete sweep with `table_o` = 8'hA5.
- **Start while busy.** Hold `start_i` high through an entire sweep. Required:
  - A single `done_o` pulse at k+9.
  - A new sweep begins only after the IDLE cycle following DONE; `sel_o` restarts at 0.

Source files
------------

// File: rtl/tt_sweeper.sv
// tt_sweeper: walks every selector code, samples result_i after a settle window
// and grades the captured truth table against a golden table.
module tt_sweeper #(
  parameter int WIDTH = 3,
  parameter int SETTLE = 0,
  parameter logic [2**WIDTH-1:0] EXPECTED = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic [WIDTH-1:0]      sel_o,
  input  logic                  result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2**WIDTH-1:0]   table_o,
  output logic                  pass_o,
  output logic [WIDTH:0]        mismatch_count_o,
  output logic [WIDTH-1:0]      fail_idx_o
);
  localparam int CW = SETTLE < 1 ? 1 : $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic sample, last, miss;
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    sample = state == DRIVE && cnt == '0;
    last = &sel_o;
    miss = sample && result_i != EXPECTED[sel_o];
    busy_o = state == DRIVE;
    done_o = state == DONE;
    state_n = state == IDLE ? (start_i ? DRIVE : IDLE) :
              state == DRIVE ? (sample && last ? DONE : DRIVE) : IDLE;
  end
  // The sweep ends on the top code, so sel_o never wraps inside a sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_o <= '0;
      cnt <= '0;
      table_o <= '0;
      pass_o <= 1'b0;
      mismatch_count_o <= '0;
      fail_idx_o <= '0;
    end else if (state == IDLE && start_i) begin
      sel_o <= '0;
      cnt <= CW'(SETTLE);
      table_o <= '0;
      pass_o <= 1'b0;
      mismatch_count_o <= '0;
      fail_idx_o <= '0;
    end else if (state == DRIVE) begin
      if (!sample) begin
        cnt <= cnt - CW'(1);
      end else begin
        table_o[sel_o] <= result_i;
        if (miss) mismatch_count_o <= mismatch_count_o + (WIDTH+1)'(1);
        if (miss && mismatch_count_o == '0) fail_idx_o <= sel_o;
        if (last) begin
          sel_o <= '0;
          pass_o <= mismatch_count_o == '0 && !miss;
        end else begin
          sel_o <= sel_o + WIDTH'(1);
          cnt <= CW'(SETTLE);
        end
      end
    end
  end
endmodule
